mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates NUM_CH byte-serial read/write requesters onto one byte-wide RAM port.
// Latency: grant registered from IDLE; write done at T+L, read done + rdata at T+L+1 (T = first XFER cycle).
// Backpressure: rdy_in low freezes all state/outputs; io_buffer_full parks I/O-space write bytes in IO_WAIT.
// Build option: define MEM_PORT_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module mem_port_arb #(
  parameter int         NUM_CH     = 2,
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_we,
  input  logic [3*NUM_CH-1:0]   req_len,
  input  logic [32*NUM_CH-1:0]  req_addr,
  input  logic [32*NUM_CH-1:0]  req_wdata,
  output logic [NUM_CH-1:0]     req_done,
  output logic [31:0]           rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    IO_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [2:0]    len_q, len_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [2:0]    win_len;
  logic [31:0]   cur_a;
  logic          byte_phase;
  logic          io_block;
  logic          issue;
  logic [1:0]    rsel;

`ifdef MEM_PORT_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  // Round-robin pick: first requester found scanning upward from ptr_q, wrapping at NUM_CH
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IW'((int'(ptr_q) + i) % NUM_CH);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end
`else
  // Fixed priority pick: scanning downward lets the lowest requesting index overwrite last
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`endif

  // Normalise the winner's byte count: only 1 and 2 are taken literally, everything else is a word
  always_comb begin
    case (req_len[3*win_idx +: 3])
      3'd1:    win_len = 3'd1;
      3'd2:    win_len = 3'd2;
      default: win_len = 3'd4;
    endcase
  end

  // Byte-cycle decode and RAM port drive; the port is all-zero whenever no byte is issued
  always_comb begin
    cur_a      = addr_q + {29'd0, cnt_q};
    byte_phase = (state_q == XFER) && (cnt_q < len_q);
    io_block   = byte_phase && we_q && (cur_a[17:16] == IO_ADDR_HI) && io_buffer_full;
    issue      = byte_phase && !io_block;
    rsel       = cnt_q[1:0] - 2'd1;
    mem_a      = issue ? cur_a : 32'd0;
    mem_wr     = issue && we_q;
    mem_dout   = (issue && we_q) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    rdata      = rdata_q;
  end

  // One-hot completion pulse for the granted channel while in DONE
  always_comb begin
    req_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_done[i] = (state_q == DONE) && (gnt_q == IW'(i));
    end
  end

  // Next-state logic; everything holds by default so rdy_in low simply skips the case
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_PORT_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            // Latch the request so a requester dropping req_valid cannot disturb the transfer
            gnt_d   = win_idx;
            we_d    = req_we[win_idx];
            len_d   = win_len;
            addr_d  = req_addr[32*win_idx +: 32];
            wdata_d = req_wdata[32*win_idx +: 32];
            cnt_d   = 3'd0;
            rdata_d = 32'd0;
            state_d = XFER;
`ifdef MEM_PORT_ARB_RR_EN
            ptr_d   = IW'((int'(win_idx) + 1) % NUM_CH);
`endif
          end
        end
        XFER: begin
          // RAM answers one cycle after the address: at count k we receive byte k-1
          if (!we_q && cnt_q != 3'd0) begin
            rdata_d[{rsel, 3'b000} +: 8] = mem_din;
          end
          if (io_block) begin
            state_d = IO_WAIT;
          end else if (cnt_q < len_q) begin
            cnt_d = cnt_q + 3'd1;
            if (we_q && (cnt_q + 3'd1 == len_q)) begin
              state_d = DONE;
            end
          end else begin
            // Read drain cycle: last byte captured above
            state_d = DONE;
          end
        end
        IO_WAIT: begin
          if (!io_buffer_full) begin
            state_d = XFER;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority over rdy_in
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      len_q   <= 3'd0;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef MEM_PORT_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_PORT_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed checks of mem_port_arb with hand-computed cycle-by-cycle expectations.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 2 units after posedge.
// Backpressure: RAM model is stalled by the same global rdy_in as the arbiter.
module tb_mem_port_arb;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [5:0]  req_len;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_done;
  logic [31:0] rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_chk    = 0;
  int n_err    = 0;
  int done_tot = 0;
  int multi    = 0;

  mem_port_arb #(.NUM_CH(2), .IO_ADDR_HI(2'b11)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_len        (req_len),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_done       (req_done),
    .rdata          (rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Read-only RAM contents used by the read tests
  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'hFFFF_FFFF: return 8'h5A;
      32'h0000_0000: return 8'h01;
      32'h0000_0001: return 8'h02;
      32'h0000_0002: return 8'h03;
      32'h0000_0003: return 8'h04;
      default:       return 8'h00;
    endcase
  endfunction

  // One-cycle read latency RAM, frozen by global ready
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= rom(mem_a);
  end

  // Count completion pulses and any cycle with more than one done bit
  always @(negedge clk_in) begin
    if (req_done != 2'b00) done_tot <= done_tot + 1;
    if ($countones(req_done) > 1) multi <= multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [31:0] a, input logic wr,
                     input logic [7:0] d, input logic [1:0] dn);
    chk({tag, ".mem_a"},    mem_a,               a);
    chk({tag, ".mem_wr"},   {31'd0, mem_wr},     {31'd0, wr});
    chk({tag, ".mem_dout"}, {24'd0, mem_dout},   {24'd0, d});
    chk({tag, ".req_done"}, {30'd0, req_done},   {30'd0, dn});
  endtask

  task automatic go();
    @(posedge clk_in);
    #1;
  endtask

  // Advance until a done pulse or the cycle budget runs out; d stays 0 on timeout
  task automatic wait_done(output logic [1:0] d, output logic [31:0] rd, output int n);
    d  = 2'b00;
    rd = 32'd0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      go();
      #1;
      n = i + 1;
      if (req_done != 2'b00) begin
        d  = req_done;
        rd = rdata;
        break;
      end
    end
  endtask

  logic [1:0]  d, ed;
  logic [31:0] rd;
  int          n;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; req_valid = '0; req_we = '0; req_len = '0;
    req_addr = '0; req_wdata = '0; io_buffer_full = 1'b0;

    // Reset state
    go(); go(); #1;
    bus("rst", 32'd0, 1'b0, 8'h00, 2'b00);
    chk("rst.rdata", rdata, 32'd0);
    rst_in = 1'b0;

    // Ch0 read len 4 at 0x100
    go(); req_valid = 2'b01; req_we = 2'b00; req_len = {3'd0, 3'd4};
    req_addr = {32'h0, 32'h100}; #1;
    bus("t1.idle", 32'd0, 1'b0, 8'h00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      go(); #1; bus("t1.byte", 32'h100 + k, 1'b0, 8'h00, 2'b00);
    end
    go(); #1; bus("t1.drain", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t1.done", 32'd0, 1'b0, 8'h00, 2'b01);
    chk("t1.rdata", rdata, 32'h4433_2211);
    req_valid = 2'b00;
    go(); #1; bus("t1.idle2", 32'd0, 1'b0, 8'h00, 2'b00);

    // Ch1 write len 2 to I/O space, buffer full for 3 cycles
    req_valid = 2'b10; req_we = 2'b10; req_len = {3'd2, 3'd0};
    req_addr = {32'h0003_0000, 32'h0}; req_wdata = {32'h0000_ABCD, 32'h0};
    go(); io_buffer_full = 1'b1; #1; bus("t2.blocked", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t2.wait1", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t2.wait2", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); io_buffer_full = 1'b0; #1; bus("t2.wait3", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t2.b0", 32'h0003_0000, 1'b1, 8'hCD, 2'b00);
    go(); #1; bus("t2.b1", 32'h0003_0001, 1'b1, 8'hAB, 2'b00);
    go(); #1; bus("t2.done", 32'd0, 1'b0, 8'h00, 2'b10);
    req_valid = 2'b00;
    go(); #1; bus("t2.idle", 32'd0, 1'b0, 8'h00, 2'b00);

    // Both channels request continuously: len-1 reads, ch0 at 0x100, ch1 at 0x101
    req_valid = 2'b11; req_we = 2'b00; req_len = {3'd1, 3'd1};
    req_addr = {32'h101, 32'h100};
    for (int t = 0; t < 4; t++) begin
      wait_done(d, rd, n);
`ifdef MEM_PORT_ARB_RR_EN
      ed = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      ed = 2'b01;
`endif
      chk("t3.grant", {30'd0, d}, {30'd0, ed});
      chk("t3.rdata", rd, (ed == 2'b01) ? 32'h11 : 32'h22);
      chk("t3.gap", n, (t == 0) ? 32'd3 : 32'd4);
    end
    req_valid = 2'b00;

    // Len-1 read at the top of the address space
    go(); req_valid = 2'b01; req_len = {3'd0, 3'd1}; req_addr = {32'h0, 32'hFFFF_FFFF}; #1;
    bus("t4.idle", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t4.b0", 32'hFFFF_FFFF, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t4.drain", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t4.done", 32'd0, 1'b0, 8'h00, 2'b01);
    chk("t4.rdata", rdata, 32'h0000_005A);
    // Len 3 is treated as a 4-byte read
    req_len = {3'd0, 3'd3}; req_addr = {32'h0, 32'h0};
    go(); #1; bus("t4.idle2", 32'd0, 1'b0, 8'h00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      go(); #1; bus("t4.len3", 32'd0 + k, 1'b0, 8'h00, 2'b00);
    end
    go(); #1; bus("t4.drain2", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t4.done2", 32'd0, 1'b0, 8'h00, 2'b01);
    chk("t4.rdata2", rdata, 32'h0403_0201);
    // Len-2 write starting at 0xFFFFFFFF wraps to address 0
    req_we = 2'b01; req_len = {3'd0, 3'd2}; req_addr = {32'h0, 32'hFFFF_FFFF};
    req_wdata = {32'h0, 32'h0000_BEEF};
    go(); #1; bus("t4.idle3", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t4.wrap0", 32'hFFFF_FFFF, 1'b1, 8'hEF, 2'b00);
    go(); #1; bus("t4.wrap1", 32'h0000_0000, 1'b1, 8'hBE, 2'b00);
    go(); #1; bus("t4.done3", 32'd0, 1'b0, 8'h00, 2'b01);
    req_valid = 2'b00;

    // Reset during byte 2 of a len-4 write
    go(); req_valid = 2'b01; req_we = 2'b01; req_len = {3'd0, 3'd4};
    req_addr = {32'h0, 32'h200}; req_wdata = {32'h0, 32'hDDCC_BBAA}; #1;
    bus("t5.idle", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t5.b0", 32'h200, 1'b1, 8'hAA, 2'b00);
    go(); #1; bus("t5.b1", 32'h201, 1'b1, 8'hBB, 2'b00);
    go(); rst_in = 1'b1; #1; bus("t5.b2", 32'h202, 1'b1, 8'hCC, 2'b00);
    // Both channels request right after reset: the pointer restarts at ch0
    go(); rst_in = 1'b0; req_valid = 2'b11; req_we = 2'b00; req_len = {3'd1, 3'd1};
    req_addr = {32'h101, 32'h100}; #1;
    bus("t5.after_rst", 32'd0, 1'b0, 8'h00, 2'b00);
    chk("t5.rdata_rst", rdata, 32'd0);
    wait_done(d, rd, n);
    chk("t5.grant", {30'd0, d}, 32'h1);
    chk("t5.rdata", rd, 32'h11);
    chk("t5.lat", n, 32'd3);
    req_valid = 2'b00;

    // rdy_in low for 5 cycles during a len-4 read
    go(); req_valid = 2'b01; req_len = {3'd0, 3'd4}; req_addr = {32'h0, 32'h100}; #1;
    bus("t6.idle", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t6.b0", 32'h100, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t6.b1", 32'h101, 1'b0, 8'h00, 2'b00);
    go(); rdy_in = 1'b0; #1; bus("t6.stall", 32'h102, 1'b0, 8'h00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      go(); #1; bus("t6.stall", 32'h102, 1'b0, 8'h00, 2'b00);
    end
    go(); rdy_in = 1'b1; #1; bus("t6.b2", 32'h102, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t6.b3", 32'h103, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t6.drain", 32'd0, 1'b0, 8'h00, 2'b00);
    go(); #1; bus("t6.done", 32'd0, 1'b0, 8'h00, 2'b01);
    chk("t6.rdata", rdata, 32'h4433_2211);
    req_valid = 2'b00;
    go(); #1; bus("t6.idle2", 32'd0, 1'b0, 8'h00, 2'b00);

    // Every transaction above completes exactly once; none after the aborted write
    chk("done_total", done_tot, 32'd11);
    chk("multi_done", multi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
